fifo_drain_ctrl: RTL

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

---
 rtl/fifo_drain_ctrl_if.sv | 29 ++
 rtl/fifo_drain_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl_if.sv
// Signal bundle between the FIFO drain controller, its source FIFO, the burst
// requester and the downstream stream consumer.
interface fifo_drain_ctrl_if #(
  parameter int FWIDTH = 32,
  parameter int LWIDTH = 8
);
  logic              F_EmptyN;
  logic [FWIDTH-1:0] F_Data;
  logic              FOutN;
  logic              Start;
  logic [LWIDTH-1:0] Burst_Len;
  logic              Busy;
  logic              Done;
  logic [FWIDTH-1:0] M_Data;
  logic              M_Valid;
  logic              M_Ready;
  logic              M_Last;
  logic [LWIDTH-1:0] Word_Cnt;

  modport master (
    input  F_EmptyN, F_Data, Start, Burst_Len, M_Ready,
    output FOutN, Busy, Done, M_Data, M_Valid, M_Last, Word_Cnt
  );

  modport slave (
    output F_EmptyN, F_Data, Start, Burst_Len, M_Ready,
    input  FOutN, Busy, Done, M_Data, M_Valid, M_Last, Word_Cnt
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Drains a burst of Burst_Len words from a FIFO with an active-low read strobe
// into a 2-entry buffer that feeds a valid/ready output stream.
module fifo_drain_ctrl #(
  parameter int FWIDTH = 32,
  parameter int LWIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  fifo_drain_ctrl_if.master  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] CAP   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [LWIDTH-1:0] remaining;
  logic [LWIDTH-1:0] remaining_dec;
  logic              last_push;
  logic              pop;
  logic              push;

  logic [FWIDTH-1:0] head_data;
  logic              head_valid;
  logic              head_last;
  logic [FWIDTH-1:0] tail_data;
  logic              tail_valid;
  logic              tail_last;

  assign pop           = head_valid & bus.M_Ready;
  assign push          = (state == CAP);
  assign remaining_dec = remaining - LWIDTH'(1);
  assign last_push     = (remaining_dec == '0);

  assign bus.M_Data  = head_data;
  assign bus.M_Valid = head_valid;
  assign bus.M_Last  = head_last;

  // A read is only launched when the buffer is guaranteed a free slot by CAP,
  // so the tail entry never overflows.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = (bus.Burst_Len == '0) ? DRAIN : WAIT;
      WAIT:    if (bus.F_EmptyN && !(tail_valid && !pop)) state_next = RD;
      RD:      state_next = CAP;
      CAP:     state_next = last_push ? DRAIN : WAIT;
      DRAIN:   if (!head_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      remaining    <= '0;
      bus.FOutN    <= 1'b1;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
      bus.Word_Cnt <= '0;
    end else begin
      state     <= state_next;
      bus.FOutN <= (state_next != RD);
      bus.Done  <= (state == DRAIN) && !head_valid;
      if (state == IDLE && bus.Start) begin
        remaining    <= bus.Burst_Len;
        bus.Word_Cnt <= '0;
        bus.Busy     <= 1'b1;
      end else if (state == DRAIN && !head_valid) begin
        bus.Busy <= 1'b0;
      end
      if (push) remaining <= remaining_dec;
      if (pop)  bus.Word_Cnt <= bus.Word_Cnt + LWIDTH'(1);
    end
  end

  // Two-entry shift buffer: the head is the output register, a pop shifts the
  // tail forward, and a push lands in the first slot free after that pop.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      head_data  <= '0;
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      tail_data  <= '0;
      tail_valid <= 1'b0;
      tail_last  <= 1'b0;
    end else if (pop) begin
      head_data  <= tail_data;
      head_valid <= tail_valid;
      head_last  <= tail_last;
      tail_valid <= 1'b0;
      tail_last  <= 1'b0;
      if (push) begin
        if (tail_valid) begin
          tail_data  <= bus.F_Data;
          tail_valid <= 1'b1;
          tail_last  <= last_push;
        end else begin
          head_data  <= bus.F_Data;
          head_valid <= 1'b1;
          head_last  <= last_push;
        end
      end
    end else if (push) begin
      if (head_valid) begin
        tail_data  <= bus.F_Data;
        tail_valid <= 1'b1;
        tail_last  <= last_push;
      end else begin
        head_data  <= bus.F_Data;
        head_valid <= 1'b1;
        head_last  <= last_push;
      end
    end
  end

endmodule
